result_wb_sched: RTL and testbench

- Write-back scheduler between the GEMM systolic output and the single-lane result saver.
- Accepts one S2P-wide tile of accumulator results per handshake and serializes it, one word per cycle.
- Generates the 4-bit result_valid tag stream, the per-run address step constants and the conv_done pulse.
- Tracks tile and kernel-group counts for one convolution run.

---
 rtl/result_wb_sched_pkg.sv | 14 +
 rtl/result_wb_serializer.sv | 32 +++
 rtl/result_wb_sched.sv | 148 ++++++++++++++
 tb/tb_result_wb_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_wb_sched_pkg.sv
// result_wb_sched_pkg: shared sizes, result_valid tag bit positions and FSM encoding
package result_wb_sched_pkg;
  localparam int S2P_SIZE    = 8;
  localparam int RESULT_SIZE = 32;
  localparam int ADDR_SIZE   = 16;
  localparam int CNT_W       = 10;
  localparam int DATA_WIDTH  = S2P_SIZE * RESULT_SIZE;
  localparam int LANE_W      = $clog2(S2P_SIZE);
  localparam int VLD_WR      = 0;
  localparam int VLD_ACT     = 1;
  localparam int VLD_FIRST   = 2;
  localparam int VLD_GRPEND  = 3;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_TILE, SHIFT, DRAIN, DONE} state_e;
endpackage

// File: rtl/result_wb_serializer.sv
// result_wb_serializer: holds one accepted tile and presents its lanes one per cycle
module result_wb_serializer
  import result_wb_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   load,
  input  logic                   step,
  input  logic [DATA_WIDTH-1:0]  data_in,
  output logic [LANE_W-1:0]      lane_cnt,
  output logic [RESULT_SIZE-1:0] result
);
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [LANE_W-1:0]     lane_cnt_q, lane_cnt_d;
  // a new tile restarts at lane 0; otherwise advance one lane per shifting cycle
  always_comb begin
    hold_d     = load ? data_in : hold_q;
    lane_cnt_d = load ? '0 : lane_cnt_q + LANE_W'(step);
  end
  // holding register and lane pointer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q     <= '0;
      lane_cnt_q <= '0;
    end else begin
      hold_q     <= hold_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end
  assign lane_cnt = lane_cnt_q;
  assign result   = hold_q[lane_cnt_q*RESULT_SIZE +: RESULT_SIZE];
endmodule

// File: rtl/result_wb_sched.sv
// result_wb_sched: sequences GEMM tiles into the single-lane saver and tracks one conv run
module result_wb_sched
  import result_wb_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [CNT_W-1:0]       cfg_t_num,
  input  logic [CNT_W-1:0]       cfg_kgroup_num,
  input  logic [ADDR_SIZE-1:0]   cfg_o_feature_size,
  input  logic [3:0]             cfg_shift,
  input  logic                   tile_vld,
  output logic                   tile_rdy,
  input  logic [DATA_WIDTH-1:0]  tile_data,
  input  logic                   w_done,
  output logic [RESULT_SIZE-1:0] result,
  output logic [3:0]             shift,
  output logic [3:0]             result_valid,
  output logic [ADDR_SIZE-1:0]   switch_kernel_addnums,
  output logic [ADDR_SIZE-1:0]   switch_kernel_group_addnums,
  output logic                   conv_done,
  output logic                   busy
);
  state_e                 state_q, state_d;
  logic                   busy_q, busy_d, conv_done_q, conv_done_d;
  logic [3:0]             shift_q, shift_d;
  logic [CNT_W-1:0]       t_num_q, t_num_d, kgroup_q, kgroup_d;
  logic [CNT_W-1:0]       tile_cnt_q, tile_cnt_d, group_cnt_q, group_cnt_d;
  logic [ADDR_SIZE-1:0]   ofs_q, ofs_d, ska_q, ska_d, skga_q, skga_d;
  logic [1:0]             drain_cnt_q, drain_cnt_d;
  logic [LANE_W-1:0]      lane_cnt;
  logic                   shifting, lane_last, tile_last, run_last, hs;

  assign shifting  = state_q == SHIFT;
  assign lane_last = lane_cnt == LANE_W'(S2P_SIZE - 1);
  assign tile_last = tile_cnt_q == t_num_q - CNT_W'(1);
  assign run_last  = tile_last && group_cnt_q == kgroup_q - CNT_W'(1);
  assign tile_rdy  = state_q == WAIT_TILE || (shifting && lane_last && !run_last);
  assign hs        = tile_vld && tile_rdy;

  result_wb_serializer u_ser (
    .clk      (clk),
    .rstn     (rstn),
    .load     (hs),
    .step     (shifting),
    .data_in  (tile_data),
    .lane_cnt (lane_cnt),
    .result   (result)
  );

  // tag stream is decoded straight from state and counters so it lines up with the lane mux
  always_comb begin
    result_valid = '0;
    result_valid[VLD_WR]     = shifting;
    result_valid[VLD_ACT]    = shifting;
    result_valid[VLD_FIRST]  = shifting && lane_cnt == '0;
    result_valid[VLD_GRPEND] = shifting && tile_last;
  end

  // run sequencing: config latch, address steps, tile/group counting, drain and done handshake
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    conv_done_d = conv_done_q;
    shift_d     = shift_q;
    t_num_d     = t_num_q;
    kgroup_d    = kgroup_q;
    ofs_d       = ofs_q;
    ska_d       = ska_q;
    skga_d      = skga_q;
    tile_cnt_d  = tile_cnt_q;
    group_cnt_d = group_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = LOAD;
        busy_d   = 1'b1;
        shift_d  = cfg_shift;
        t_num_d  = cfg_t_num;
        kgroup_d = cfg_kgroup_num;
        ofs_d    = cfg_o_feature_size;
      end
      LOAD: begin
        ska_d       = ofs_q - ADDR_SIZE'(S2P_SIZE - 1);
        skga_d      = (ofs_q - (ADDR_SIZE'(t_num_q) - ADDR_SIZE'(1))) << LANE_W;
        tile_cnt_d  = '0;
        group_cnt_d = '0;
        state_d     = (t_num_q == '0 || kgroup_q == '0) ? DONE : WAIT_TILE;
        conv_done_d = t_num_q == '0 || kgroup_q == '0;
      end
      WAIT_TILE: if (tile_vld) state_d = SHIFT;
      SHIFT: if (lane_last) begin
        tile_cnt_d  = tile_last ? '0 : tile_cnt_q + CNT_W'(1);
        group_cnt_d = group_cnt_q + CNT_W'(tile_last);
        drain_cnt_d = '0;
        state_d     = run_last ? DRAIN : tile_vld ? SHIFT : WAIT_TILE;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 2'd1;
        state_d     = drain_cnt_q == 2'd2 ? DONE : DRAIN;
        conv_done_d = drain_cnt_q == 2'd2;
      end
      DONE: if (w_done) begin
        state_d     = IDLE;
        conv_done_d = 1'b0;
        busy_d      = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and run registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      conv_done_q <= 1'b0;
      shift_q     <= '0;
      t_num_q     <= '0;
      kgroup_q    <= '0;
      ofs_q       <= '0;
      ska_q       <= '0;
      skga_q      <= '0;
      tile_cnt_q  <= '0;
      group_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      conv_done_q <= conv_done_d;
      shift_q     <= shift_d;
      t_num_q     <= t_num_d;
      kgroup_q    <= kgroup_d;
      ofs_q       <= ofs_d;
      ska_q       <= ska_d;
      skga_q      <= skga_d;
      tile_cnt_q  <= tile_cnt_d;
      group_cnt_q <= group_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign busy                        = busy_q;
  assign conv_done                   = conv_done_q;
  assign shift                       = shift_q;
  assign switch_kernel_addnums       = ska_q;
  assign switch_kernel_group_addnums = skga_q;
endmodule

// File: tb/tb_result_wb_sched.sv
// tb_result_wb_sched: table-driven and randomized runs checked against a tile-queue model
module tb_result_wb_sched;
  import result_wb_sched_pkg::*;

  typedef struct {
    int          t;
    int          g;
    logic [15:0] ofs;
    logic [3:0]  sh;
    logic [15:0] ska;
    logic [15:0] skga;
    int          mode;
  } vec_t;

  logic                   clk = 0, rstn = 0, start = 0, tile_vld = 0, w_done = 0;
  logic [CNT_W-1:0]       cfg_t_num = '0, cfg_kgroup_num = '0;
  logic [ADDR_SIZE-1:0]   cfg_o_feature_size = '0;
  logic [3:0]             cfg_shift = '0;
  logic [DATA_WIDTH-1:0]  tile_data = '0;
  logic                   tile_rdy, conv_done, busy;
  logic [RESULT_SIZE-1:0] result;
  logic [3:0]             shift, result_valid;
  logic [ADDR_SIZE-1:0]   switch_kernel_addnums, switch_kernel_group_addnums;
  int                     nvec = 0, nerr = 0;

  result_wb_sched dut (
    .clk                         (clk),
    .rstn                        (rstn),
    .start                       (start),
    .cfg_t_num                   (cfg_t_num),
    .cfg_kgroup_num              (cfg_kgroup_num),
    .cfg_o_feature_size          (cfg_o_feature_size),
    .cfg_shift                   (cfg_shift),
    .tile_vld                    (tile_vld),
    .tile_rdy                    (tile_rdy),
    .tile_data                   (tile_data),
    .w_done                      (w_done),
    .result                      (result),
    .shift                       (shift),
    .result_valid                (result_valid),
    .switch_kernel_addnums       (switch_kernel_addnums),
    .switch_kernel_group_addnums (switch_kernel_group_addnums),
    .conv_done                   (conv_done),
    .busy                        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " result"}, result, 0);
    chk({tag, " result_valid"}, result_valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " conv_done"}, conv_done, 0);
    chk({tag, " tile_rdy"}, tile_rdy, 0);
    chk({tag, " shift"}, shift, 0);
    chk({tag, " ska"}, switch_kernel_addnums, 0);
    chk({tag, " skga"}, switch_kernel_group_addnums, 0);
  endtask

  // mode 0: tile_vld always high, 1: random tile_vld, 2: 5-cycle bubble before tile 1
  task automatic run(input int t, input int g, input logic [15:0] ofs, input logic [3:0] sh,
                     input logic [15:0] e_ska, input logic [15:0] e_skga, input int mode);
    logic [DATA_WIDTH-1:0]  tiles[$];
    logic [RESULT_SIZE-1:0] exp_data[$];
    logic [3:0]             exp_tag[$];
    logic [DATA_WIDTH-1:0]  tl;
    logic [RESULT_SIZE-1:0] w;
    int                     wc[$];
    int                     nt, n, words, hs_n, rdy_n, tidx, low, done_c;
    bit                     hs, done;
    nt = t * g;
    n = nt * S2P_SIZE;
    words = 0; hs_n = 0; rdy_n = 0; tidx = 0; low = 0; done_c = 0; hs = 0; done = 0;
    for (int gi = 0; gi < g; gi++)
      for (int ti = 0; ti < t; ti++) begin
        for (int k = 0; k < S2P_SIZE; k++) begin
          w = $urandom;
          tl[k*RESULT_SIZE +: RESULT_SIZE] = w;
          exp_data.push_back(w);
          exp_tag.push_back({ti == t - 1, k == 0, 2'b11});
        end
        tiles.push_back(tl);
      end
    cfg_t_num = CNT_W'(t);
    cfg_kgroup_num = CNT_W'(g);
    cfg_o_feature_size = ofs;
    cfg_shift = sh;
    start = 1;
    tick();
    start = 0;
    cfg_t_num = CNT_W'($urandom);
    cfg_kgroup_num = CNT_W'($urandom);
    cfg_o_feature_size = ADDR_SIZE'($urandom);
    cfg_shift = 4'($urandom);
    chk("busy after start", busy, 1);
    for (int c = 0; c < 3000; c++) begin
      if (hs) tidx++;
      if (result_valid != 0) begin
        if (words < n) begin
          chk($sformatf("word %0d data", words), result, exp_data[words]);
          chk($sformatf("word %0d tag", words), result_valid, exp_tag[words]);
        end else chk("extra word", result_valid, 0);
        wc.push_back(c);
        words++;
      end
      if (conv_done) begin
        done = 1;
        done_c = c;
        break;
      end
      tile_vld = tidx < nt && !(mode == 2 && tidx == 1 && low < 12) && (mode != 1 || $urandom_range(0, 1) == 1);
      if (mode == 2 && tidx == 1) low++;
      tile_data = tidx < nt ? tiles[tidx] : ~tile_data;
      start = $urandom_range(0, 7) == 0;
      @(negedge clk);
      hs = tile_vld && tile_rdy;
      hs_n += int'(hs);
      rdy_n += int'(tile_rdy);
      tick();
    end
    start = 0;
    tile_vld = 0;
    chk("conv_done seen", done, 1);
    chk("word count", words, n);
    chk("handshakes", hs_n, nt);
    if (n > 0 && wc.size() > 0) chk("drain gap", done_c - wc[wc.size()-1], 4);
    if (mode == 0 && wc.size() == n && n > 0) begin
      chk("no gaps", wc[n-1] - wc[0], n - 1);
      chk("rdy pulses", rdy_n, nt);
    end
    if (mode == 2 && wc.size() > 8) chk("bubble length", wc[8] - wc[7], 6);
    chk("ska", switch_kernel_addnums, e_ska);
    chk("skga", switch_kernel_group_addnums, e_skga);
    chk("shift latched", shift, sh);
    repeat (2) begin
      tick();
      chk("conv_done held", conv_done, 1);
      chk("busy held", busy, 1);
    end
    w_done = 1;
    tick();
    w_done = 0;
    chk("conv_done cleared", conv_done, 0);
    chk("busy cleared", busy, 0);
    chk("idle result_valid", result_valid, 0);
  endtask

  initial begin
    vec_t                  tbl[7];
    logic [DATA_WIDTH-1:0] rt;
    int                    words, t, g, o;
    tbl[0] = '{2, 1, 16'd9,   4'd3,  16'd2,     16'd64,  0};
    tbl[1] = '{3, 2, 16'd9,   4'd5,  16'd2,     16'd56,  0};
    tbl[2] = '{2, 1, 16'd9,   4'd1,  16'd2,     16'd64,  2};
    tbl[3] = '{0, 2, 16'd9,   4'd7,  16'd2,     16'd80,  0};
    tbl[4] = '{3, 0, 16'd10,  4'd2,  16'd3,     16'd64,  1};
    tbl[5] = '{4, 3, 16'd5,   4'd15, 16'd65534, 16'd16,  1};
    tbl[6] = '{1, 1, 16'd100, 4'd9,  16'd93,    16'd800, 0};
    repeat (3) tick();
    chk_idle_outputs("reset");
    rstn = 1;
    tick();
    for (int i = 0; i < 7; i++)
      run(tbl[i].t, tbl[i].g, tbl[i].ofs, tbl[i].sh, tbl[i].ska, tbl[i].skga, tbl[i].mode);

    for (int k = 0; k < DATA_WIDTH / 32; k++) rt[k*32 +: 32] = $urandom;
    cfg_t_num = 2;
    cfg_kgroup_num = 1;
    cfg_o_feature_size = 20;
    cfg_shift = 4;
    start = 1;
    tick();
    start = 0;
    tile_vld = 1;
    tile_data = rt;
    words = 0;
    for (int c = 0; c < 40 && words < 5; c++) begin
      tick();
      if (result_valid != 0) words++;
    end
    chk("reached lane 4", words, 5);
    chk("lane 4 data", result, rt[4*RESULT_SIZE +: RESULT_SIZE]);
    rstn = 0;
    #1;
    chk_idle_outputs("mid-run reset");
    tile_vld = 0;
    @(negedge clk);
    rstn = 1;
    tick();
    run(2, 1, 16'd9, 4'd6, 16'd2, 16'd64, 0);

    repeat (8) begin
      t = $urandom_range(1, 4);
      g = $urandom_range(1, 3);
      o = $urandom_range(0, 65535);
      run(t, g, 16'(o), 4'($urandom), 16'(o - S2P_SIZE + 1), 16'(o * S2P_SIZE - (t - 1) * S2P_SIZE),
          $urandom_range(0, 1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
